// File: rtl/audio_rx_ctl_if.sv
// I2S ADC pin group plus the decoded sample outputs of audio_rx_ctl.
// master = the receive controller, slave = the ADC / sample consumer side.
interface audio_rx_ctl_if;
  logic        audio_sdout;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        sample_valid;

  modport master (
    input  audio_sdout,
    output audio_mclk,
    output audio_sck,
    output audio_lrck,
    output audio_left,
    output audio_right,
    output sample_valid
  );

  modport slave (
    output audio_sdout,
    input  audio_mclk,
    input  audio_sck,
    input  audio_lrck,
    input  audio_left,
    input  audio_right,
    input  sample_valid
  );
endinterface

// File: rtl/audio_rx_ctl.sv
// I2S receive controller: derives MCLK/SCK/LRCK from a free-running 9-bit frame
// counter and deframes 16-bit left/right words (one-bit-delay framing) from the ADC.
module audio_rx_ctl (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  audio_rx_ctl_if.master aud
);

  localparam logic [8:0] CNT_LEFT_START = 9'd23;
  localparam logic [8:0] CNT_LEFT_DONE  = 9'd263;
  localparam logic [8:0] CNT_RIGHT_DONE = 9'd7;

  logic [8:0]  cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [14:0] sh_q, sh_d;
  logic [15:0] lbuf_q, lbuf_d;
  logic        run_q, run_d;
  logic        armed_q, armed_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic        valid_q, valid_d;
  logic        mclk_q, mclk_d;
  logic        sck_q, sck_d;
  logic        lrck_q, lrck_d;
  logic        sample_s;
  logic [15:0] word_s;

  // Next-state logic: clock generation, bit capture and word completion.
  always_comb begin
    cnt_d    = cnt_q + 9'd1;
    // Clock outputs copy the next count so SCK rises on the very edge that samples.
    mclk_d   = cnt_d[1];
    sck_d    = cnt_d[3];
    lrck_d   = cnt_d[8];
    sync1_d  = aud.audio_sdout;
    sync2_d  = sync1_q;
    sample_s = (cnt_q[3:0] == 4'd7);
    // Only the 15 most recent bits are ever read, so the oldest is not stored.
    word_s   = {sh_q, sync2_q};
    sh_d     = sh_q;
    lbuf_d   = lbuf_q;
    run_d    = run_q;
    armed_d  = armed_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;

    if (!en) begin
      run_d   = 1'b0;
      armed_d = 1'b0;
    end else if (sample_s) begin
      sh_d = word_s[14:0];
      // run_q marks a left word whose every bit was sampled with en high.
      case (cnt_q)
        CNT_LEFT_START: begin
          run_d = 1'b1;
        end
        CNT_LEFT_DONE: begin
          if (run_q) begin
            lbuf_d  = word_s;
            armed_d = 1'b1;
          end else begin
            armed_d = 1'b0;
          end
        end
        CNT_RIGHT_DONE: begin
          if (armed_q) begin
            left_d  = lbuf_q;
            right_d = word_s;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end else begin
      sh_d = sh_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 9'd0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sh_q    <= 15'd0;
      lbuf_q  <= 16'd0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
      left_q  <= 16'd0;
      right_q <= 16'd0;
      valid_q <= 1'b0;
      mclk_q  <= 1'b0;
      sck_q   <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sh_q    <= sh_d;
      lbuf_q  <= lbuf_d;
      run_q   <= run_d;
      armed_q <= armed_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      mclk_q  <= mclk_d;
      sck_q   <= sck_d;
      lrck_q  <= lrck_d;
    end
  end

  assign aud.audio_mclk   = mclk_q;
  assign aud.audio_sck    = sck_q;
  assign aud.audio_lrck   = lrck_q;
  assign aud.audio_left   = left_q;
  assign aud.audio_right  = right_q;
  assign aud.sample_valid = valid_q;

endmodule

// File: tb/tb_audio_rx_ctl.sv
// Self-checking bench for audio_rx_ctl: an I2S ADC model drives word pairs and a
// frame-level reference predicts clocks, sample_valid and the captured words.
module tb_audio_rx_ctl;

  logic clk;
  logic rst;
  logic en;

  audio_rx_ctl_if aif ();

  audio_rx_ctl dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .aud (aif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vecs = 0;
  int          errs = 0;
  int          run  = 0;
  logic [8:0]  m_cnt = 9'd0;
  logic [15:0] wl = 16'd0, wr = 16'd0;
  logic [15:0] nl = 16'd0, nr = 16'd0;
  logic [15:0] exp_l = 16'd0, exp_r = 16'd0;
  logic        exp_v = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("sample_valid", {15'd0, aif.sample_valid}, {15'd0, exp_v});
    chk("audio_left", aif.audio_left, exp_l);
    chk("audio_right", aif.audio_right, exp_r);
    chk("audio_mclk", {15'd0, aif.audio_mclk}, {15'd0, m_cnt[1]});
    chk("audio_sck", {15'd0, aif.audio_sck}, {15'd0, m_cnt[3]});
    chk("audio_lrck", {15'd0, aif.audio_lrck}, {15'd0, m_cnt[8]});
  endtask

  // ADC: the 32 bit periods from count 16 onward carry {left, right} MSB first.
  task automatic drive_sdout();
    logic [31:0] pair;
    logic [8:0]  o;
    pair = {wl, wr};
    o    = m_cnt - 9'd16;
    aif.audio_sdout = pair[5'd31 - o[8:4]];
  endtask

  // A pair completes at count 7 only if en stayed high over the whole
  // left+right word span: the 497 edges from count 23 to count 7.
  task automatic tick();
    logic [8:0] pre;
    @(posedge clk);
    exp_v = 1'b0;
    if (rst) begin
      pre   = m_cnt;
      m_cnt = m_cnt + 9'd1;
      run   = en ? run + 1 : 0;
      if (pre == 9'd7 && run >= 497) begin
        exp_v = 1'b1;
        exp_l = wl;
        exp_r = wr;
      end
      if (m_cnt == 9'd16) begin
        wl = nl;
        wr = nr;
      end
    end
    #1;
    check_all();
    drive_sdout();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_cnt = 9'd0;
    run   = 0;
    exp_l = 16'd0;
    exp_r = 16'd0;
    exp_v = 1'b0;
    check_all();
    drive_sdout();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    drive_sdout();
    #2;
    // Reset held for 10 clocks, then release with silent input.
    do_reset();
    ticks(10);
    rst = 1'b1;
    ticks(519);
    chk("no_valid_before_520", {15'd0, aif.sample_valid}, 16'd0);
    tick();
    chk("first_valid_at_520", {15'd0, aif.sample_valid}, 16'd1);
    ticks(10);

    // Constant ones.
    nl = 16'hFFFF; nr = 16'hFFFF;
    ticks(1100);

    // Fixed pattern.
    nl = 16'hA5C3; nr = 16'h1234;
    ticks(1100);

    // Enable gap of 600 clocks starting at count 100.
    for (int i = 0; i < 600 && m_cnt != 9'd100; i++) tick();
    en = 1'b0;
    ticks(600);
    en = 1'b1;
    ticks(1600);

    // Mid-frame reset at count 300.
    for (int i = 0; i < 600 && m_cnt != 9'd300; i++) tick();
    do_reset();
    ticks(3);
    rst = 1'b1;
    ticks(520);
    chk("rst_valid_at_520", {15'd0, aif.sample_valid}, 16'd1);
    chk("rst_left_a5c3", aif.audio_left, 16'hA5C3);
    chk("rst_right_1234", aif.audio_right, 16'h1234);
    ticks(20);

    // Channel order and one-bit-delay alignment.
    nl = 16'h8000; nr = 16'h0001;
    ticks(1100);
    chk("swap_left_8000", aif.audio_left, 16'h8000);
    chk("swap_right_0001", aif.audio_right, 16'h0001);

    // Random words with occasional random enable gaps.
    for (int k = 0; k < 8; k++) begin
      nl = 16'($urandom);
      nr = 16'($urandom);
      ticks(512 + int'($urandom_range(0, 600)));
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0;
        ticks(int'($urandom_range(1, 700)));
        en = 1'b1;
      end
    end
    ticks(1100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
